instr_fetch_unit: RTL and testbench

Reader side of the instruction memory. It owns the program counter, drives the word address to the combinational instruction memory, and registers the returned word with its PC. It presents the pair to decode through a valid/ready handshake and supports redirect (branch/jump), halt and resume. It sits between the instruction memory and the decode/control stage of the MIPS-subset datapath.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_out_reg.sv | 37 +++
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 tb/tb_instr_fetch_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   localparam int unsigned AW_DEF = 8;
   localparam int unsigned DW_DEF = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/fetch_out_reg.sv
// Valid/ready holding register for the fetched {pc, instruction} pair.
// Flush wins over load; a transfer without a load empties the register.
module fetch_out_reg
   import fetch_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          flush,
   input  logic          ready,
   input  logic [AW-1:0] load_pc,
   input  logic [DW-1:0] load_instr,
   output logic [AW-1:0] pc_out,
   output logic [DW-1:0] instr_out,
   output logic          valid
);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_out    <= '0;
         instr_out <= DW'(NOP_INSTR);
         valid     <= 1'b0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         pc_out    <= load_pc;
         instr_out <= load_instr;
         valid     <= 1'b1;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule : fetch_out_reg

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational instruction memory
// and hands {pc, instr} to decode with redirect, halt and resume support.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned AW       = AW_DEF,
   parameter int unsigned DW       = DW_DEF,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned CW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   output logic [AW-1:0] imem_addr,
   input  logic [DW-1:0] imem_data,
   output logic [DW-1:0] instr_out,
   output logic [AW-1:0] pc_out,
   output logic          instr_valid,
   input  logic          instr_ready,
   input  logic          redirect_en,
   input  logic [AW-1:0] redirect_pc,
   input  logic          halt,
   output logic          halted,
   output logic [CW-1:0] fetch_count
);

   fetch_state_t  state_q, state_d;
   logic [AW-1:0] pc_q;
   logic          capture;

   assign imem_addr = pc_q;

   // State register plus the registered halted flag that mirrors it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         halted  <= 1'b0;
      end else begin
         state_q <= state_d;
         halted  <= (state_d == HALT);
      end
   end

   // Next state and capture decision; priority is redirect > halt > capture.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         RUN: begin
            if (redirect_en) begin
               state_d = RUN;
            end else if (halt) begin
               state_d = HALT;
            end else begin
               capture = !instr_valid || instr_ready;
            end
         end
         HALT: begin
            if (redirect_en) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= AW'(RESET_PC);
      end else if (redirect_en) begin
         pc_q <= redirect_pc;
      end else if (capture) begin
         pc_q <= pc_q + AW'(1);
      end
   end

   // Saturating count of captured instructions.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count <= '0;
      end else if (capture && (fetch_count != {CW{1'b1}})) begin
         fetch_count <= fetch_count + CW'(1);
      end
   end

   fetch_out_reg #(
      .AW (AW),
      .DW (DW)
   ) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (capture),
      .flush      (redirect_en),
      .ready      (instr_ready),
      .load_pc    (pc_q),
      .load_instr (imem_data),
      .pc_out     (pc_out),
      .instr_out  (instr_out),
      .valid      (instr_valid)
   );

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural instruction memory.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  imem_addr;
   logic [31:0] imem_data;
   logic [31:0] instr_out;
   logic [7:0]  pc_out;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_en;
   logic [7:0]  redirect_pc;
   logic        halt;
   logic        halted;
   logic [15:0] fetch_count;

   logic [31:0] mem [256];
   int          passes = 0;
   int          total  = 0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr];

   instr_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .instr_out   (instr_out),
      .pc_out      (pc_out),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checks the whole observable state in one go.
   task automatic chk_all(input string tag, input logic v, input logic [7:0] pco,
                          input logic [31:0] ins, input logic [7:0] addr,
                          input logic [15:0] cnt, input logic hl);
      chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
      if (v) begin
         chk({tag, ".pc_out"}, 32'(pc_out), 32'(pco));
         chk({tag, ".instr"}, instr_out, ins);
      end
      chk({tag, ".addr"}, 32'(imem_addr), 32'(addr));
      chk({tag, ".count"}, 32'(fetch_count), 32'(cnt));
      chk({tag, ".halted"}, 32'(halted), 32'(hl));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 | 32'(i);
      mem[0] = 32'h2001_0003;
      mem[1] = 32'h2002_0009;
      mem[2] = 32'h0022_1020;

      rst = 1'b1; instr_ready = 1'b1; redirect_en = 1'b0;
      redirect_pc = 8'h00; halt = 1'b0;
      step(); step();
      chk("reset.pc_out", 32'(pc_out), 32'h0);
      chk("reset.instr", instr_out, 32'h0);
      chk_all("reset", 1'b0, 8'h00, 32'h0, 8'h00, 16'd0, 1'b0);

      // Streaming at full rate.
      rst = 1'b0;
      step(); chk_all("run0", 1'b1, 8'h00, 32'h2001_0003, 8'h01, 16'd1, 1'b0);
      step(); chk_all("run1", 1'b1, 8'h01, 32'h2002_0009, 8'h02, 16'd2, 1'b0);

      // Backpressure holds everything.
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(); chk_all("stall", 1'b1, 8'h01, 32'h2002_0009, 8'h02, 16'd2, 1'b0);
      end
      instr_ready = 1'b1;
      step(); chk_all("run2", 1'b1, 8'h02, 32'h0022_1020, 8'h03, 16'd3, 1'b0);

      // Redirect flushes the pending word.
      redirect_en = 1'b1; redirect_pc = 8'h05;
      step(); chk_all("redir.flush", 1'b0, 8'h00, 32'h0, 8'h05, 16'd3, 1'b0);
      redirect_en = 1'b0;
      step(); chk_all("redir.word", 1'b1, 8'h05, 32'hC000_0005, 8'h06, 16'd4, 1'b0);

      // Park at pc=3, then halt.
      redirect_en = 1'b1; redirect_pc = 8'h03;
      step(); chk_all("to3", 1'b0, 8'h00, 32'h0, 8'h03, 16'd4, 1'b0);
      redirect_en = 1'b0; halt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); chk_all("halt", 1'b0, 8'h00, 32'h0, 8'h03, 16'd4, 1'b1);
      end
      halt = 1'b0;
      step(); chk_all("halt.stay", 1'b0, 8'h00, 32'h0, 8'h03, 16'd4, 1'b1);
      step(); chk_all("halt.stay2", 1'b0, 8'h00, 32'h0, 8'h03, 16'd4, 1'b1);

      // Resume via redirect to 0.
      redirect_en = 1'b1; redirect_pc = 8'h00;
      step(); chk_all("resume", 1'b0, 8'h00, 32'h0, 8'h00, 16'd4, 1'b0);
      redirect_en = 1'b0;
      step(); chk_all("resume.word", 1'b1, 8'h00, 32'h2001_0003, 8'h01, 16'd5, 1'b0);

      // Address wrap 0xFE, 0xFF, 0x00.
      redirect_en = 1'b1; redirect_pc = 8'hFE;
      step(); chk_all("wrap.redir", 1'b0, 8'h00, 32'h0, 8'hFE, 16'd5, 1'b0);
      redirect_en = 1'b0;
      step(); chk_all("wrap.fe", 1'b1, 8'hFE, 32'hC000_00FE, 8'hFF, 16'd6, 1'b0);
      step(); chk_all("wrap.ff", 1'b1, 8'hFF, 32'hC000_00FF, 8'h00, 16'd7, 1'b0);
      step(); chk_all("wrap.00", 1'b1, 8'h00, 32'h2001_0003, 8'h01, 16'd8, 1'b0);

      // Halt with a word pending: it stays until decode takes it.
      instr_ready = 1'b0; halt = 1'b1;
      step(); chk_all("halt.pend", 1'b1, 8'h00, 32'h2001_0003, 8'h01, 16'd8, 1'b1);
      instr_ready = 1'b1; halt = 1'b0;
      step(); chk_all("halt.drain", 1'b0, 8'h00, 32'h0, 8'h01, 16'd8, 1'b1);

      // Redirect and halt together: redirect wins.
      redirect_en = 1'b1; halt = 1'b1; redirect_pc = 8'h10;
      step(); chk_all("both", 1'b0, 8'h00, 32'h0, 8'h10, 16'd8, 1'b0);
      redirect_en = 1'b0; halt = 1'b0;
      step(); chk_all("both.word", 1'b1, 8'h10, 32'hC000_0010, 8'h11, 16'd9, 1'b0);

      // Reset in the middle of a stall.
      instr_ready = 1'b0;
      step(); chk_all("pre_rst", 1'b1, 8'h10, 32'hC000_0010, 8'h11, 16'd9, 1'b0);
      rst = 1'b1;
      step();
      chk("rst.pc_out", 32'(pc_out), 32'h0);
      chk("rst.instr", instr_out, 32'h0);
      chk_all("rst", 1'b0, 8'h00, 32'h0, 8'h00, 16'd0, 1'b0);
      rst = 1'b0; instr_ready = 1'b1;
      step(); chk_all("post_rst", 1'b1, 8'h00, 32'h2001_0003, 8'h01, 16'd1, 1'b0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule : tb_instr_fetch_unit
